// File: rtl/alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_ctrl
// Purpose  : Two-requester round-robin front end for a set of ALU units.
//            Accepts one command, issues it to a single unit for one cycle,
//            waits up to three cycles for the unit flag (else flags a
//            timeout), then holds the response until the consumer takes it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_ctrl #(
  parameter int IN_DATA_WIDTH = 16,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [1:0]                 REQ_VALID,
  input  logic [2*IN_DATA_WIDTH-1:0] REQ_A,
  input  logic [2*IN_DATA_WIDTH-1:0] REQ_B,
  input  logic [7:0]                 REQ_FUN,
  output logic [1:0]                 REQ_READY,
  output logic [IN_DATA_WIDTH-1:0]   A,
  output logic [IN_DATA_WIDTH-1:0]   B,
  output logic [1:0]                 ALU_FUN,
  output logic                       ARITH_Enable,
  output logic                       LOGIC_Enable,
  output logic                       CMP_Enable,
  output logic                       SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0]       ALU_OUT,
  input  logic                       UNIT_FLAG,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic                       RSP_ID,
  output logic [OUT_WIDTH-1:0]       RSP_DATA,
  output logic                       RSP_ERR,
  output logic                       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Number of flag-less WAIT cycles before a timeout, minus one.
  localparam logic [1:0] C_WAIT_LAST = 2'd2;

  state_t                     state_q, state_d;
  logic                       last_gnt_q, last_gnt_d;
  logic [IN_DATA_WIDTH-1:0]   a_q, a_d;
  logic [IN_DATA_WIDTH-1:0]   b_q, b_d;
  logic [3:0]                 fun_q, fun_d;
  logic                       id_q, id_d;
  logic [OUT_WIDTH-1:0]       data_q, data_d;
  logic                       err_q, err_d;
  logic [1:0]                 cnt_q, cnt_d;

  logic                       gnt;
  logic                       accept;

  // Round-robin pick: on contention the requester that did not win last time
  // goes next; otherwise whichever requester is valid.
  always_comb begin
    gnt = (&REQ_VALID) ? ~last_gnt_q : ~REQ_VALID[0];
    // Ready is withheld while reset is asserted so nothing is accepted then.
    REQ_READY = {2{rst && (state_q == S_IDLE)}} & REQ_VALID
              & (gnt ? 2'b10 : 2'b01);
    accept    = |REQ_READY;
  end

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      id_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      id_q       <= id_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: capture on accept, one issue cycle, bounded wait, hold.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    id_d       = id_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = gnt ? REQ_A[2*IN_DATA_WIDTH-1:IN_DATA_WIDTH]
                        : REQ_A[IN_DATA_WIDTH-1:0];
          b_d     = gnt ? REQ_B[2*IN_DATA_WIDTH-1:IN_DATA_WIDTH]
                        : REQ_B[IN_DATA_WIDTH-1:0];
          fun_d   = gnt ? REQ_FUN[7:4] : REQ_FUN[3:0];
          id_d    = gnt;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (UNIT_FLAG) begin
          data_d  = ALU_OUT;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == C_WAIT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          last_gnt_d = id_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unit enables: exactly one, and only during the issue cycle.
  always_comb begin
    ARITH_Enable = 1'b0;
    LOGIC_Enable = 1'b0;
    CMP_Enable   = 1'b0;
    SHIFT_Enable = 1'b0;
    if (state_q == S_ISSUE) begin
      case (fun_q[3:2])
        2'b00:   ARITH_Enable = 1'b1;
        2'b01:   LOGIC_Enable = 1'b1;
        2'b10:   CMP_Enable   = 1'b1;
        default: SHIFT_Enable = 1'b1;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_FUN   = fun_q[1:0];
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ID    = id_q;
  assign RSP_DATA  = data_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter_ctrl
// Purpose  : Directed self-checking bench for alu_arbiter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_ctrl;

  localparam int W  = 16;
  localparam int OW = 16;

  logic           CLK;
  logic           rst;
  logic [1:0]     REQ_VALID;
  logic [2*W-1:0] REQ_A;
  logic [2*W-1:0] REQ_B;
  logic [7:0]     REQ_FUN;
  logic [1:0]     REQ_READY;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     ALU_FUN;
  logic           ARITH_Enable;
  logic           LOGIC_Enable;
  logic           CMP_Enable;
  logic           SHIFT_Enable;
  logic [OW-1:0]  ALU_OUT;
  logic           UNIT_FLAG;
  logic           RSP_VALID;
  logic           RSP_READY;
  logic           RSP_ID;
  logic [OW-1:0]  RSP_DATA;
  logic           RSP_ERR;
  logic           BUSY;

  int errors = 0;
  int checks = 0;

  alu_arbiter_ctrl #(.IN_DATA_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .CLK(CLK), .rst(rst),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUN(REQ_FUN),
    .REQ_READY(REQ_READY), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .ARITH_Enable(ARITH_Enable), .LOGIC_Enable(LOGIC_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .ALU_OUT(ALU_OUT), .UNIT_FLAG(UNIT_FLAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  wire [3:0] en = {ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".A"},        32'(A),         32'h0);
    check({tag, ".B"},        32'(B),         32'h0);
    check({tag, ".ALU_FUN"},  32'(ALU_FUN),   32'h0);
    check({tag, ".EN"},       32'(en),        32'h0);
    check({tag, ".RSP_VALID"},32'(RSP_VALID), 32'h0);
    check({tag, ".RSP_ID"},   32'(RSP_ID),    32'h0);
    check({tag, ".RSP_DATA"}, 32'(RSP_DATA),  32'h0);
    check({tag, ".RSP_ERR"},  32'(RSP_ERR),   32'h0);
    check({tag, ".BUSY"},     32'(BUSY),      32'h0);
    check({tag, ".REQ_READY"},32'(REQ_READY), 32'h0);
  endtask

  initial begin
    logic [1:0]  exp_id;
    logic [15:0] exp_a;
    rst       = 1'b0;
    REQ_VALID = 2'b00;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_FUN   = '0;
    ALU_OUT   = '0;
    UNIT_FLAG = 1'b0;
    RSP_READY = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b1;

    // Single CMP command from requester 0
    REQ_VALID = 2'b01;
    REQ_A     = {16'h0000, 16'd5};
    REQ_B     = {16'h0000, 16'd5};
    REQ_FUN   = {4'b0000, 4'b1001};
    #1;
    check("t1.ready", 32'(REQ_READY), 32'h1);
    step();                                   // ISSUE
    REQ_VALID = 2'b00;
    UNIT_FLAG = 1'b1;
    ALU_OUT   = 16'd1;
    check("t1.issue_en",  32'(en),        32'b0010);
    check("t1.alu_fun",   32'(ALU_FUN),   32'h1);
    check("t1.A",         32'(A),         32'd5);
    check("t1.B",         32'(B),         32'd5);
    check("t1.busy",      32'(BUSY),      32'h1);
    check("t1.ready_off", 32'(REQ_READY), 32'h0);
    step();                                   // WAIT
    check("t1.wait_en",   32'(en),        32'h0);
    check("t1.wait_vld",  32'(RSP_VALID), 32'h0);
    step();                                   // RESP
    UNIT_FLAG = 1'b0;
    check("t1.rsp_vld",   32'(RSP_VALID), 32'h1);
    check("t1.rsp_data",  32'(RSP_DATA),  32'h1);
    check("t1.rsp_id",    32'(RSP_ID),    32'h0);
    check("t1.rsp_err",   32'(RSP_ERR),   32'h0);
    RSP_READY = 1'b1;
    step();                                   // IDLE
    RSP_READY = 1'b0;
    check("t1.vld_drop",  32'(RSP_VALID), 32'h0);
    check("t1.idle_busy", 32'(BUSY),      32'h0);

    // Timeout: ARITH command from requester 1, unit never answers
    REQ_VALID = 2'b10;
    REQ_A     = {16'h00AA, 16'h0000};
    REQ_B     = {16'h00BB, 16'h0000};
    REQ_FUN   = {4'b0010, 4'b0000};
    #1;
    check("t2.ready", 32'(REQ_READY), 32'h2);
    step();                                   // ISSUE
    REQ_VALID = 2'b00;
    check("t2.issue_en", 32'(en),      32'b1000);
    check("t2.alu_fun",  32'(ALU_FUN), 32'h2);
    check("t2.A",        32'(A),       32'h00AA);
    step();                                   // WAIT 1
    check("t2.en_off",   32'(en),        32'h0);
    step();                                   // WAIT 2
    step();                                   // WAIT 3
    check("t2.w3_vld",   32'(RSP_VALID), 32'h0);
    REQ_VALID = 2'b11;
    step();                                   // RESP
    check("t2.rsp_vld",  32'(RSP_VALID), 32'h1);
    check("t2.rsp_err",  32'(RSP_ERR),   32'h1);
    check("t2.rsp_data", 32'(RSP_DATA),  32'h0);
    check("t2.rsp_id",   32'(RSP_ID),    32'h1);

    // Consumer stalls five cycles with both requesters pending
    UNIT_FLAG = 1'b1;
    ALU_OUT   = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3.vld",   32'(RSP_VALID), 32'h1);
      check("t3.err",   32'(RSP_ERR),   32'h1);
      check("t3.data",  32'(RSP_DATA),  32'h0);
      check("t3.id",    32'(RSP_ID),    32'h1);
      check("t3.ready", 32'(REQ_READY), 32'h0);
      check("t3.busy",  32'(BUSY),      32'h1);
    end
    RSP_READY = 1'b1;
    step();                                   // IDLE, last grant = 1

    // Round-robin with both valid, unit select swept 00..11
    REQ_A = {16'h1111, 16'h2222};
    REQ_B = {16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      REQ_FUN = {2'(k), 2'b11, 2'(k), 2'b11};
      ALU_OUT = 16'h0100 + 16'(k);
      exp_id  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a   = (k % 2 == 0) ? 16'h2222 : 16'h1111;
      #1;
      check("rr.ready", 32'(REQ_READY), 32'(exp_id));
      step();                                 // ISSUE
      check("rr.en",      32'(en),      32'(4'b1000 >> k));
      check("rr.alu_fun", 32'(ALU_FUN), 32'h3);
      check("rr.A",       32'(A),       32'(exp_a));
      step();                                 // WAIT (flag high)
      step();                                 // RESP
      check("rr.vld",  32'(RSP_VALID), 32'h1);
      check("rr.id",   32'(RSP_ID),    32'(k % 2));
      check("rr.data", 32'(RSP_DATA),  32'h0100 + 32'(k));
      step();                                 // IDLE
    end

    // Requester 0 completes alone so the last grant becomes 0
    REQ_VALID = 2'b01;
    REQ_FUN   = 8'h00;
    ALU_OUT   = 16'h0055;
    step(); step(); step(); step();
    check("pre.idle", 32'(BUSY), 32'h0);

    // Reset during WAIT
    UNIT_FLAG = 1'b0;
    step();                                   // ISSUE
    step();                                   // WAIT
    check("rst.in_wait", 32'(BUSY), 32'h1);
    REQ_VALID = 2'b11;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step();
    rst = 1'b1;
    #1;
    check("rst.regrant", 32'(REQ_READY), 32'h1);
    check("rst.no_rsp",  32'(RSP_VALID), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 16, operand width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, result width.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ_VALID  input  2  bit n: requester n presents a command.
REQ-006 SHALL have port REQ_A  input  2*IN_DATA_WIDTH  operand A per requester; requester n uses slice n.
REQ-007 SHALL have port REQ_B  input  2*IN_DATA_WIDTH  operand B per requester; requester n uses slice n.
REQ-008 SHALL have port REQ_FUN  input  8  4-bit function per requester; [3:2] selects the unit, [1:0] is the unit op.
REQ-009 SHALL have port REQ_READY  output  2  bit n: command from requester n accepted this cycle.
REQ-010 SHALL have port A  output  IN_DATA_WIDTH  registered operand A to the ALU units.
REQ-011 SHALL have port B  output  IN_DATA_WIDTH  registered operand B to the ALU units.
REQ-012 SHALL have port ALU_FUN  output  2  unit op code.
REQ-013 SHALL have port ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable  output  1 each  unit enables.
REQ-014 SHALL have port ALU_OUT  input  OUT_WIDTH  OR of the unit outputs.
REQ-015 SHALL have port UNIT_FLAG  input  1  OR of the unit done flags.
REQ-016 SHALL have port RSP_VALID  output  1  response available.
REQ-017 SHALL have port RSP_READY  input  1  consumer takes the response.
REQ-018 SHALL have port RSP_ID  output  1  requester index of the response.
REQ-019 SHALL have port RSP_DATA  output  OUT_WIDTH  result.
REQ-020 SHALL have port RSP_ERR  output  1  unit timeout.
REQ-021 SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-022 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: grant is round-robin; with both REQ_VALID bits high, the requester other than LAST_GNT wins; with one bit high, that requester wins.
REQ-024 REQ_READY[g] SHALL be combinational and high only in IDLE for the granted g; the other bit SHALL be 0.
REQ-025 On REQ_VALID[g]&REQ_READY[g], A/B/function/ID SHALL be captured, and the FSM SHALL go to ISSUE.
REQ-026 ISSUE SHALL last exactly 1 cycle: ALU_FUN=fun[1:0]; exactly one enable high per fun[3:2] (00 ARITH, 01 LOGIC, 10 CMP, 11 SHIFT); next state WAIT.
REQ-027 Enables SHALL be 0 in every state except ISSUE.
REQ-028 A and B SHALL hold the captured operands until the next accepted command.
REQ-029 WAIT: if UNIT_FLAG=1, capture ALU_OUT into RSP_DATA, set RSP_ERR=0, and go to RESP.
REQ-030 WAIT: a 2-bit counter SHALL clear on entry; if UNIT_FLAG stays 0 for 3 WAIT cycles, set RSP_DATA=0, RSP_ERR=1, and go to RESP.
REQ-031 RESP: RSP_VALID=1; RSP_DATA/RSP_ID/RSP_ERR SHALL be stable while RSP_READY=0.
REQ-032 RESP with RSP_READY=1: LAST_GNT=RSP_ID; next state IDLE; RSP_VALID drops the next cycle.
REQ-033 Minimum latency, accept edge to RSP_VALID high: 2 cycles (ISSUE, WAIT, then RESP).
REQ-034 No new command SHALL be accepted from ISSUE through RESP; requesters hold REQ_VALID.
REQ-035 UNIT_FLAG/ALU_OUT SHALL be ignored outside WAIT.

Reset
REQ-036 rst low SHALL immediately force: state IDLE; LAST_GNT=1; A=B=0; ALU_FUN=0; all enables 0; RSP_VALID=0; RSP_ID=0; RSP_DATA=0; RSP_ERR=0; WAIT counter 0.
REQ-037 Reset mid-operation SHALL abandon the command with no response; after release the FSM arbitrates afresh from IDLE.

Verification
REQ-038 Requester 0, A=5, B=5, FUN=4'b1001; UNIT_FLAG=1 with ALU_OUT=1 in WAIT -> REQ_READY=2'b01 at accept; CMP_Enable high one cycle, ALU_FUN=01; 2 cycles later RSP_VALID=1, RSP_DATA=1, RSP_ID=0, RSP_ERR=0.
REQ-039 Both REQ_VALID held high, RSP_READY=1 -> grant order 0,1,0,1; REQ_READY is never 2'b11.
REQ-040 FUN=4'b0010 to requester 1, UNIT_FLAG held 0 -> ARITH_Enable one pulse; after 3 WAIT cycles RSP_VALID=1, RSP_ERR=1, RSP_DATA=0, RSP_ID=1.
REQ-041 RSP_READY low 5 cycles in RESP, REQ_VALID=2'b11 -> response fields unchanged; REQ_READY=0; BUSY=1 throughout.
REQ-042 rst pulsed low during WAIT -> all outputs 0 at once; after release the next grant goes to requester 0.
REQ-043 FUN[3:2] swept 00..11 -> ARITH, LOGIC, CMP, SHIFT enable respectively; never two enables at once.
